// File: rtl/rgb_fader_pkg.sv
// Shared types and constants for the RGB hue-wheel fader.
// The colour map lives here so every consumer agrees on the wheel.
package rgb_fader_pkg;

  localparam int NUM_SEGS = 6;
  localparam int SEG_W    = $clog2(NUM_SEGS);
  localparam int SPEED_W  = 2;
  localparam int PWM_W    = 8;

  typedef enum logic [SEG_W-1:0] {
    SEG_R_UP_G = 3'd0,
    SEG_R_DN   = 3'd1,
    SEG_B_UP   = 3'd2,
    SEG_G_DN   = 3'd3,
    SEG_R_UP   = 3'd4,
    SEG_B_DN   = 3'd5
  } seg_e;

  typedef struct packed {
    logic [PWM_W-1:0] r;
    logic [PWM_W-1:0] g;
    logic [PWM_W-1:0] b;
  } rgb_t;

  // ~lvl is 255-lvl for 8-bit levels, which keeps each boundary continuous
  function automatic rgb_t colour_map(input seg_e seg, input logic [PWM_W-1:0] lvl);
    rgb_t c;
    case (seg)
      SEG_R_UP_G: c = '{r: 8'hFF, g: lvl,     b: 8'h00};
      SEG_R_DN:   c = '{r: ~lvl,  g: 8'hFF,   b: 8'h00};
      SEG_B_UP:   c = '{r: 8'h00, g: 8'hFF,   b: lvl};
      SEG_G_DN:   c = '{r: 8'h00, g: ~lvl,    b: 8'hFF};
      SEG_R_UP:   c = '{r: lvl,   g: 8'h00,   b: 8'hFF};
      SEG_B_DN:   c = '{r: 8'hFF, g: 8'h00,   b: ~lvl};
      default:    c = '{r: 8'hFF, g: 8'h00,   b: 8'h00};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb_fader_if.sv
// Key inputs and PWM/status outputs of the fader, bundled for the board top.
interface rgb_fader_if;
  import rgb_fader_pkg::*;

  logic               key_speed;
  logic               key_pause;
  logic [PWM_W-1:0]   RedPWM;
  logic [PWM_W-1:0]   GreenPWM;
  logic [PWM_W-1:0]   BluePWM;
  logic [SEG_W-1:0]   segment;
  logic [SPEED_W-1:0] speed;
  logic               paused;

  modport master (
    input  key_speed, key_pause,
    output RedPWM, GreenPWM, BluePWM, segment, speed, paused
  );

  modport slave (
    output key_speed, key_pause,
    input  RedPWM, GreenPWM, BluePWM, segment, speed, paused
  );

endinterface

// File: rtl/key_debounce.sv
// Synchronise and debounce an active-low board key; pulse once per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk12MHz,
  input  logic reset,
  input  logic key_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             pressed_r;
  logic [CNT_W-1:0] cnt_r;

  // two-flop synchroniser, idles at the released (high) level
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // any return to the accepted level restarts the stability count
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      stable_r  <= 1'b1;
      pressed_r <= 1'b0;
    end else begin
      pressed_r <= 1'b0;
      if (sync2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r     <= {CNT_W{1'b0}};
        stable_r  <= sync2_r;
        pressed_r <= stable_r & ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign pressed = pressed_r;

endmodule

// File: rtl/rgb_fader.sv
// Hue-wheel colour generator: prescaled seg/level walker with debounced speed/pause keys.
module rgb_fader
  import rgb_fader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_BASE       = 46875
) (
  input  logic          clk12MHz,
  input  logic          reset,
  rgb_fader_if.master   bus
);

  localparam int PRE_W = $clog2(STEP_BASE + 1);
  localparam logic [PRE_W-1:0] STEP_BASE_W = PRE_W'(STEP_BASE);

  logic               speed_press_s;
  logic               pause_press_s;
  seg_e               seg_r;
  seg_e               seg_nx_s;
  logic [PWM_W-1:0]   level_r;
  logic [PWM_W-1:0]   level_nx_s;
  logic [SPEED_W-1:0] speed_r;
  logic [SPEED_W-1:0] speed_nx_s;
  logic               paused_r;
  logic               paused_nx_s;
  logic [PRE_W-1:0]   prescaler_r;
  logic [PRE_W-1:0]   prescaler_nx_s;
  logic [PRE_W-1:0]   period_s;
  logic               tick_s;
  rgb_t               rgb_r;
  rgb_t               rgb_nx_s;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_speed (
    .clk12MHz (clk12MHz),
    .reset    (reset),
    .key_n    (bus.key_speed),
    .pressed  (speed_press_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pause (
    .clk12MHz (clk12MHz),
    .reset    (reset),
    .key_n    (bus.key_pause),
    .pressed  (pause_press_s)
  );

  // next-state: tick decision, wheel advance, key effects, colour of the next state
  always_comb begin
    period_s       = STEP_BASE_W >> speed_r;
    tick_s         = ~paused_r && (prescaler_r == period_s - PRE_W'(1));
    seg_nx_s       = seg_r;
    level_nx_s     = level_r;
    prescaler_nx_s = prescaler_r;

    if (tick_s) begin
      level_nx_s = level_r + 8'd1;
      if (level_r == 8'hFF) begin
        case (seg_r)
          SEG_R_UP_G: seg_nx_s = SEG_R_DN;
          SEG_R_DN:   seg_nx_s = SEG_B_UP;
          SEG_B_UP:   seg_nx_s = SEG_G_DN;
          SEG_G_DN:   seg_nx_s = SEG_R_UP;
          SEG_R_UP:   seg_nx_s = SEG_B_DN;
          SEG_B_DN:   seg_nx_s = SEG_R_UP_G;
          default:    seg_nx_s = SEG_R_UP_G;
        endcase
      end else begin
        seg_nx_s = seg_r;
      end
    end else begin
      level_nx_s = level_r;
    end

    // a speed change restarts the step interval, even on a tick cycle
    if (speed_press_s || tick_s) begin
      prescaler_nx_s = {PRE_W{1'b0}};
    end else if (paused_r) begin
      prescaler_nx_s = prescaler_r;
    end else begin
      prescaler_nx_s = prescaler_r + PRE_W'(1);
    end

    if (speed_press_s) begin
      speed_nx_s = speed_r + 2'd1;
    end else begin
      speed_nx_s = speed_r;
    end

    paused_nx_s = paused_r ^ pause_press_s;
    rgb_nx_s    = colour_map(seg_nx_s, level_nx_s);
  end

  // state and registered outputs
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      seg_r       <= SEG_R_UP_G;
      level_r     <= 8'd0;
      speed_r     <= 2'd0;
      paused_r    <= 1'b0;
      prescaler_r <= {PRE_W{1'b0}};
      rgb_r       <= '{r: 8'hFF, g: 8'h00, b: 8'h00};
    end else begin
      seg_r       <= seg_nx_s;
      level_r     <= level_nx_s;
      speed_r     <= speed_nx_s;
      paused_r    <= paused_nx_s;
      prescaler_r <= prescaler_nx_s;
      rgb_r       <= rgb_nx_s;
    end
  end

  assign bus.RedPWM   = rgb_r.r;
  assign bus.GreenPWM = rgb_r.g;
  assign bus.BluePWM  = rgb_r.b;
  assign bus.segment  = seg_r;
  assign bus.speed    = speed_r;
  assign bus.paused   = paused_r;

endmodule

// File: tb/tb_rgb_fader.sv
// Scoreboard bench for rgb_fader: a hue-index model predicts every cycle's outputs.
module tb_rgb_fader;

  logic clk12MHz = 1'b0;
  logic reset;

  always #5 clk12MHz = ~clk12MHz;

  rgb_fader_if bus_if ();

  rgb_fader #(.DEBOUNCE_CYCLES(4), .STEP_BASE(8)) dut (
    .clk12MHz (clk12MHz),
    .reset    (reset),
    .bus      (bus_if)
  );

  typedef struct {
    int r;
    int g;
    int b;
    int seg;
    int spd;
    int pau;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model: hue index 0..1535, prescaler, speed, pause
  int h, pre, spd, pau, cyc;
  int s_from, s_hold, p_from, p_hold;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // one channel as a trapezoid over the wheel, x measured from the start of its plateau
  function automatic int chan(input int x);
    if (x < 512)       return 255;
    else if (x < 768)  return 255 - (x - 512);
    else if (x < 1280) return 0;
    else               return x - 1280;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.r   = chan((h + 256)  % 1536);
    e.g   = chan((h + 1280) % 1536);
    e.b   = chan((h + 768)  % 1536);
    e.seg = h / 256;
    e.spd = spd;
    e.pau = pau;
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, "_R"},     int'(bus_if.RedPWM),   e.r);
    chk({tag, "_G"},     int'(bus_if.GreenPWM), e.g);
    chk({tag, "_B"},     int'(bus_if.BluePWM),  e.b);
    chk({tag, "_seg"},   int'(bus_if.segment),  e.seg);
    chk({tag, "_speed"}, int'(bus_if.speed),    e.spd);
    chk({tag, "_pause"}, int'(bus_if.paused),   e.pau);
  endtask

  // drive keys for the next edge, predict that edge, then compare at the falling edge
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int per;
      bit ev_s;
      bit ev_p;
      bit tick;
      cyc++;
      bus_if.key_speed = !(cyc >= s_from && cyc < s_from + s_hold);
      bus_if.key_pause = !(cyc >= p_from && cyc < p_from + p_hold);
      ev_s = (s_hold >= 4) && (cyc == s_from + 6);
      ev_p = (p_hold >= 4) && (cyc == p_from + 6);
      per  = 8 >> spd;
      tick = (pau == 0) && (pre == per - 1);
      if (tick) h = (h + 1) % 1536;
      if (ev_s || tick) pre = 0;
      else if (pau == 0) pre = pre + 1;
      if (ev_s) spd = (spd + 1) % 4;
      if (ev_p) pau = 1 - pau;
      exp_q.push_back(expect_now());
      @(posedge clk12MHz);
      @(negedge clk12MHz);
      pop_check(tag);
    end
  endtask

  task automatic press_speed(input int hold);
    s_from = cyc + 1;
    s_hold = hold;
  endtask

  task automatic press_pause(input int hold);
    p_from = cyc + 1;
    p_hold = hold;
  endtask

  // called at a falling edge; reset takes effect without waiting for the clock
  task automatic do_reset();
    bus_if.key_speed = 1'b1;
    bus_if.key_pause = 1'b1;
    s_hold = 0;
    p_hold = 0;
    reset  = 1'b1;
    #1;
    h = 0; pre = 0; spd = 0; pau = 0;
    exp_q.push_back(expect_now());
    pop_check("rst_async");
    @(posedge clk12MHz);
    @(negedge clk12MHz);
    exp_q.push_back(expect_now());
    pop_check("rst_edge");
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    bus_if.key_speed = 1'b1;
    bus_if.key_pause = 1'b1;
    cyc = 0; s_from = -100; s_hold = 0; p_from = -100; p_hold = 0;
    h = 0; pre = 0; spd = 0; pau = 0;
    @(negedge clk12MHz);
    do_reset();

    run(1536 * 8, "wheel");
    chk("rev_seg", int'(bus_if.segment), 0);

    press_pause(2);  run(20,  "glitch");
    press_pause(10); run(20,  "pause_on");
    chk("paused_set", int'(bus_if.paused), 1);
    run(200, "frozen");
    press_pause(10); run(30,  "resume");

    for (int k = 0; k < 3; k++) begin
      press_speed(6);
      run(20, "spd_up");
    end
    chk("speed3", int'(bus_if.speed), 3);
    run(20, "fast");
    press_speed(6); run(30, "spd_wrap");

    press_speed(6); press_pause(6); run(20, "both");
    press_pause(6); run(20, "unpause");

    guard = 0;
    while (h != 868 && guard < 8000) begin
      run(1, "seek");
      guard++;
    end
    chk("seek_seg3_lvl100", h, 868);
    chk("pre_rst_seg", int'(bus_if.segment), 3);

    do_reset();
    run(20, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
